// File: rtl/cordic_pkg.sv
// ---------------------------------------------------------------------------
// cordic_pkg
//
// Shared definitions for the CORDIC blocks (the pipelined rotation-mode
// rotator and the iterative vectoring engine).
//
// Contents:
//   atan_lut(i, angle_w) : atan(2^-i) as a binary angle of width angle_w
//                          (2^angle_w codes = 2*pi), rounded from a 32-bit
//                          master table.
//   KINV_Q15, KINV_SHIFT : reciprocal CORDIC gain, 1/K ~= 19898 / 2^15.
//   BAM_PI               : pi as a 32-bit binary angle (0x8000_0000).
//   vec_state_t          : state encoding of the vectoring engine FSM.
// ---------------------------------------------------------------------------
package cordic_pkg;

    localparam int KINV_Q15   = 19898;
    localparam int KINV_SHIFT = 15;

    localparam logic [31:0] BAM_PI = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        POST = 2'd2,
        DONE = 2'd3
    } vec_state_t;

    // The master table is atan(2^-i) * 2^32 / (2*pi). Other angle widths are
    // derived from it: narrower widths are rounded, wider widths are padded
    // with zero LSBs. Entries past i=30 are below one 32-bit LSB and read 0.
    function automatic logic [63:0] atan_lut(input int unsigned i,
                                             input int unsigned angle_w);
        logic [63:0] v;
        v = 64'd0;
        case (i)
            0:  v = 64'h2000_0000;
            1:  v = 64'h12E4_051E;
            2:  v = 64'h09FB_385B;
            3:  v = 64'h0511_11D4;
            4:  v = 64'h028B_0D43;
            5:  v = 64'h0145_D7E1;
            6:  v = 64'h00A2_F61E;
            7:  v = 64'h0051_7C55;
            8:  v = 64'h0028_BE53;
            9:  v = 64'h0014_5F2F;
            10: v = 64'h000A_2F98;
            11: v = 64'h0005_17CC;
            12: v = 64'h0002_8BE6;
            13: v = 64'h0001_45F3;
            14: v = 64'h0000_A2FA;
            15: v = 64'h0000_517D;
            16: v = 64'h0000_28BE;
            17: v = 64'h0000_145F;
            18: v = 64'h0000_0A30;
            19: v = 64'h0000_0518;
            20: v = 64'h0000_028C;
            21: v = 64'h0000_0146;
            22: v = 64'h0000_00A3;
            23: v = 64'h0000_0051;
            24: v = 64'h0000_0029;
            25: v = 64'h0000_0014;
            26: v = 64'h0000_000A;
            27: v = 64'h0000_0005;
            28: v = 64'h0000_0003;
            29: v = 64'h0000_0001;
            30: v = 64'h0000_0001;
            default: v = 64'd0;
        endcase
        if (angle_w < 32) begin
            v = (v + (64'd1 << (31 - angle_w))) >> (32 - angle_w);
        end else begin
            v = v << (angle_w - 32);
        end
        return v;
    endfunction

endpackage

// File: rtl/cordic_vec_step.sv
// ---------------------------------------------------------------------------
// cordic_vec_step
//
// One vectoring-mode CORDIC micro-rotation, purely combinational. The shift
// amount is a runtime value (barrel shifter) so a single instance can serve
// every iteration of the iterative engine; it also selects the angle LUT
// entry.
//
// Direction is chosen to drive y towards zero:
//   y >= 0 : x' = x + (y>>>i), y' = y - (x>>>i), z' = z + atan(2^-i)
//   y <  0 : x' = x - (y>>>i), y' = y + (x>>>i), z' = z - atan(2^-i)
//
// Parameters:
//   W       : signed width of x/y
//   ANGLE_W : binary-angle width of z (wraps modulo 2^ANGLE_W)
//   SHIFT_W : width of the shift / iteration index
//
// Ports:
//   x, y           in  W        : current vector (two's complement)
//   z              in  ANGLE_W  : accumulated angle
//   shift          in  SHIFT_W  : iteration index i
//   x_next, y_next out W        : rotated vector
//   z_next         out ANGLE_W  : updated angle
// ---------------------------------------------------------------------------
module cordic_vec_step
    import cordic_pkg::*;
#(
    parameter int W       = 21,
    parameter int ANGLE_W = 32,
    parameter int SHIFT_W = 5
) (
    input  logic [W-1:0]       x,
    input  logic [W-1:0]       y,
    input  logic [ANGLE_W-1:0] z,
    input  logic [SHIFT_W-1:0] shift,
    output logic [W-1:0]       x_next,
    output logic [W-1:0]       y_next,
    output logic [ANGLE_W-1:0] z_next
);

    logic signed [W-1:0] x_s;
    logic signed [W-1:0] y_s;
    logic signed [W-1:0] x_shr;
    logic signed [W-1:0] y_shr;
    logic [ANGLE_W-1:0]  angle;

    always_comb begin
        x_s    = $signed(x);
        y_s    = $signed(y);
        x_shr  = x_s >>> shift;
        y_shr  = y_s >>> shift;
        angle  = ANGLE_W'(atan_lut(32'(shift), ANGLE_W));
        x_next = x;
        y_next = y;
        z_next = z;
        // Both updates use the pre-rotation x and y.
        if (!y_s[W-1]) begin
            x_next = x_s + y_shr;
            y_next = y_s - x_shr;
            z_next = z + angle;
        end else begin
            x_next = x_s - y_shr;
            y_next = y_s + x_shr;
            z_next = z - angle;
        end
    end

endmodule

// File: rtl/cordic_vectoring_iter.sv
// ---------------------------------------------------------------------------
// cordic_vectoring_iter
//
// Iterative vectoring-mode CORDIC: converts a Cartesian sample (x, y) into
// magnitude and phase = atan2(y, x), one micro-rotation per clock through a
// single shared cordic_vec_step datapath.
//
// Sequence: IDLE (accept + fold) -> ROT x ITER -> POST (scale, register
// outputs) -> DONE (hold until out_ready). Latency is ITER+1 edges from the
// accept edge to out_valid; a new sample can be taken every ITER+3 cycles.
//
// Parameters:
//   XY_W      : signed width of x_in / y_in
//   ANGLE_W   : phase width, binary angle (2^ANGLE_W codes = 2*pi)
//   ITER      : number of micro-rotations, 1..ANGLE_W-2
//   GUARD     : fractional guard bits on the internal x/y
//   GAIN_COMP : 1 = scale magnitude by 1/K, 0 = raw K-scaled magnitude
//
// Ports:
//   clk        in  1         : clock
//   rst_n      in  1         : asynchronous active-low reset
//   in_valid   in  1         : input sample valid
//   in_ready   out 1         : engine idle, sample accepted on in_valid
//   x_in       in  XY_W      : signed x
//   y_in       in  XY_W      : signed y
//   out_valid  out 1         : result valid, held until out_ready
//   out_ready  in  1         : downstream accepts the result
//   magnitude  out XY_W+1    : unsigned magnitude
//   phase      out ANGLE_W   : signed binary-angle atan2(y, x)
// ---------------------------------------------------------------------------
module cordic_vectoring_iter
    import cordic_pkg::*;
#(
    parameter int XY_W      = 16,
    parameter int ANGLE_W   = 32,
    parameter int ITER      = 16,
    parameter int GUARD     = 3,
    parameter int GAIN_COMP = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XY_W-1:0]     x_in,
    input  logic [XY_W-1:0]     y_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XY_W:0]       magnitude,
    output logic [ANGLE_W-1:0]  phase
);

    // Two extra integer bits cover the ~2.33x worst-case vector growth and
    // make negating the most negative input exact.
    localparam int W      = XY_W + 2 + GUARD;
    localparam int CNT_W  = $clog2(ANGLE_W);
    localparam int MAG_W  = XY_W + 1;
    localparam int PROD_W = W + 16;

    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(ITER - 1);
    localparam logic [ANGLE_W-1:0] PI_CODE  = {1'b1, {(ANGLE_W-1){1'b0}}};

    vec_state_t state;
    vec_state_t state_next;

    logic [CNT_W-1:0]    cnt;
    logic signed [W-1:0] x_reg;
    logic signed [W-1:0] y_reg;
    logic [ANGLE_W-1:0]  z_reg;
    logic                zero_flag;

    logic [W-1:0]        x_ext;
    logic [W-1:0]        y_ext;
    logic [W-1:0]        x_load;
    logic [W-1:0]        y_load;
    logic [ANGLE_W-1:0]  z_load;

    logic [W-1:0]        x_step;
    logic [W-1:0]        y_step;
    logic [ANGLE_W-1:0]  z_step;

    logic [W-1:0]        mag_raw;
    logic [PROD_W-1:0]   prod;
    logic [PROD_W-1:0]   mag_full;
    logic [MAG_W-1:0]    mag_out;

    // Sign-extend by the two headroom bits, then append the guard bits.
    assign x_ext = {{(W-XY_W){x_in[XY_W-1]}}, x_in} << GUARD;
    assign y_ext = {{(W-XY_W){y_in[XY_W-1]}}, y_in} << GUARD;

    // Fold left-half-plane samples into the right half by a pi rotation so
    // the micro-rotations only need to cover +-99.9 degrees.
    always_comb begin
        x_load = x_ext;
        y_load = y_ext;
        z_load = '0;
        if (x_in[XY_W-1]) begin
            x_load = -x_ext;
            y_load = -y_ext;
            z_load = PI_CODE;
        end
    end

    cordic_vec_step #(
        .W       (W),
        .ANGLE_W (ANGLE_W),
        .SHIFT_W (CNT_W)
    ) u_step (
        .x      (x_reg),
        .y      (y_reg),
        .z      (z_reg),
        .shift  (cnt),
        .x_next (x_step),
        .y_next (y_step),
        .z_next (z_step)
    );

    // x is non-negative after the fold and only grows, so dropping the guard
    // bits gives an unsigned magnitude directly. The gain compensation result
    // is truncated, matching the Q15 fixed-point definition.
    always_comb begin
        mag_raw  = x_reg >>> GUARD;
        prod     = PROD_W'(mag_raw) * PROD_W'(KINV_Q15);
        mag_full = PROD_W'(mag_raw);
        if (GAIN_COMP != 0) begin
            mag_full = prod >> KINV_SHIFT;
        end
        mag_out  = MAG_W'(mag_full);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = ROT;
                end
            end
            ROT: begin
                if (cnt == CNT_LAST) begin
                    state_next = POST;
                end
            end
            POST: begin
                state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers. magnitude/phase are written only in POST so they
    // stay bit-stable through DONE and after the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            x_reg     <= '0;
            y_reg     <= '0;
            z_reg     <= '0;
            zero_flag <= 1'b0;
            magnitude <= '0;
            phase     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_reg     <= x_load;
                        y_reg     <= y_load;
                        z_reg     <= z_load;
                        zero_flag <= (x_in == '0) && (y_in == '0);
                        cnt       <= '0;
                    end
                end
                ROT: begin
                    x_reg <= x_step;
                    y_reg <= y_step;
                    z_reg <= z_step;
                    if (cnt != CNT_LAST) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                POST: begin
                    // atan2(0, 0) is undefined; report a clean zero instead
                    // of the angle the iterations drift to.
                    if (zero_flag) begin
                        magnitude <= '0;
                        phase     <= '0;
                    end else begin
                        magnitude <= mag_out;
                        phase     <= z_reg;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_vectoring_iter.sv
// ---------------------------------------------------------------------------
// tb_cordic_vectoring_iter
//
// Self-checking bench for cordic_vectoring_iter. Two instances run in
// lockstep on the same stimulus: dut (GAIN_COMP=1) and dut_raw (GAIN_COMP=0).
// Expected values come from a table of known points and from a real-number
// reference (sqrt / atan2 and the product of the per-iteration gains).
// ---------------------------------------------------------------------------
module tb_cordic_vectoring_iter;

    localparam int XY_W    = 16;
    localparam int ANGLE_W = 32;
    localparam int ITER    = 16;
    localparam int GUARD   = 3;

    localparam longint PH_TOL  = 65536;
    localparam longint MAG_TOL = 4;
    localparam real    PI      = 3.14159265358979323846;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [XY_W-1:0]     x_in;
    logic [XY_W-1:0]     y_in;
    logic                out_valid;
    logic                out_ready;
    logic [XY_W:0]       magnitude;
    logic [ANGLE_W-1:0]  phase;

    logic                in_ready_raw;
    logic                out_valid_raw;
    logic [XY_W:0]       magnitude_raw;
    logic [ANGLE_W-1:0]  phase_raw;

    int checks = 0;
    int errors = 0;
    real kGain;

    typedef struct {
        string  name;
        int     x;
        int     y;
        longint expMag;
        longint expRaw;
        longint expPhase;
    } vec_t;

    vec_t vecs[6];

    cordic_vectoring_iter #(
        .XY_W(XY_W), .ANGLE_W(ANGLE_W), .ITER(ITER), .GUARD(GUARD), .GAIN_COMP(1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .magnitude (magnitude),
        .phase     (phase)
    );

    cordic_vectoring_iter #(
        .XY_W(XY_W), .ANGLE_W(ANGLE_W), .ITER(ITER), .GUARD(GUARD), .GAIN_COMP(0)
    ) dut_raw (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_raw),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid_raw),
        .out_ready (out_ready),
        .magnitude (magnitude_raw),
        .phase     (phase_raw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit in case some bounded loop is still missed.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Real-valued reference: ideal magnitude, K-scaled magnitude, and
    // atan2 expressed as a 32-bit binary angle.
    task automatic refModel(input int x, input int y, output longint mag,
                            output longint rawMag, output longint ph);
        real r;
        real a;
        r      = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
        a      = $atan2(real'(y), real'(x));
        mag    = longint'(r);
        rawMag = longint'(r * kGain);
        ph     = longint'(32'(longint'(a / (2.0 * PI) * 4294967296.0)));
    endtask

    task automatic checkOutput(input string name, input longint act,
                               input longint exp, input longint tol,
                               input bit isPhase);
        longint diff;
        checks++;
        if (isPhase) diff = longint'(int'(32'(act - exp)));
        else         diff = act - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) tol %0d",
                     name, act, act, exp, exp, tol);
        end
    endtask

    // Waits for in_ready, presents one sample for a single accept edge and
    // returns the number of edges until out_valid (100 means timeout).
    task automatic applyStimulus(input int x, input int y, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            step();
            guard++;
        end
        in_valid = 1'b1;
        x_in     = 16'(x);
        y_in     = 16'(y);
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
    endtask

    task automatic releaseOutput();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic runChecked(input string name, input int x, input int y);
        longint m;
        longint rm;
        longint p;
        int     lat;
        refModel(x, y, m, rm, p);
        applyStimulus(x, y, lat);
        checkOutput({name, " latency"}, lat, 17, 0, 0);
        checkOutput({name, " mag"}, magnitude, m, MAG_TOL, 0);
        checkOutput({name, " raw mag"}, magnitude_raw, rm, MAG_TOL, 0);
        checkOutput({name, " phase"}, phase, p, PH_TOL, 1);
        releaseOutput();
    endtask

    initial begin
        int     lat;
        longint m;
        longint rm;
        longint p;

        kGain = 1.0;
        for (int i = 0; i < ITER; i++) begin
            kGain = kGain * $sqrt(1.0 + $pow(2.0, -2.0 * i));
        end

        vecs[0] = '{"pos_x",    16384,      0, 16384, 26981, 64'h0000_0000};
        vecs[1] = '{"pos_y",        0,  16384, 16384, 26981, 64'h4000_0000};
        vecs[2] = '{"neg_x",   -16384,      0, 16384, 26981, 64'h8000_0000};
        vecs[3] = '{"q3_diag", -10000, -10000, 14142, 23289, 64'hA000_0000};
        vecs[4] = '{"min_min", -32768, -32768, 46341, 76312, 64'hA000_0000};
        vecs[5] = '{"zero",         0,      0,     0,     0, 64'h0000_0000};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x_in      = '0;
        y_in      = '0;

        #1;
        step();
        step();
        checkOutput("reset in_ready", in_ready, 1, 0, 0);
        checkOutput("reset out_valid", out_valid, 0, 0, 0);
        checkOutput("reset magnitude", magnitude, 0, 0, 0);
        checkOutput("reset phase", phase, 0, 0, 1);
        rst_n = 1'b1;
        step();

        $display("[TB] table vectors");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].x, vecs[i].y, lat);
            checkOutput({vecs[i].name, " latency"}, lat, 17, 0, 0);
            checkOutput({vecs[i].name, " mag"}, magnitude, vecs[i].expMag, MAG_TOL, 0);
            checkOutput({vecs[i].name, " raw mag"}, magnitude_raw, vecs[i].expRaw, MAG_TOL, 0);
            checkOutput({vecs[i].name, " phase"}, phase, vecs[i].expPhase, PH_TOL, 1);
            releaseOutput();
        end
        checkOutput("zero mag exact", magnitude, 0, 0, 0);
        checkOutput("zero phase exact", phase, 0, 0, 1);

        $display("[TB] random vectors");
        for (int i = 0; i < 10; i++) begin
            real ang;
            real r;
            int  rx;
            int  ry;
            ang = (real'($urandom_range(0, 35999)) / 36000.0) * 2.0 * PI - PI;
            r   = real'($urandom_range(16384, 32000));
            rx  = int'(r * $cos(ang));
            ry  = int'(r * $sin(ang));
            runChecked("random", rx, ry);
        end

        $display("[TB] backpressure");
        begin
            logic [XY_W:0]      heldMag;
            logic [ANGLE_W-1:0] heldPh;
            bit                 stableOk;
            bit                 readyLow;
            refModel(12345, -6789, m, rm, p);
            applyStimulus(12345, -6789, lat);
            heldMag  = magnitude;
            heldPh   = phase;
            stableOk = 1'b1;
            readyLow = 1'b1;
            for (int c = 0; c < 10; c++) begin
                if (c == 3) begin
                    in_valid = 1'b1;
                    x_in     = 16'(-20000);
                    y_in     = 16'(5000);
                end else begin
                    in_valid = 1'b0;
                end
                step();
                if (!out_valid || magnitude != heldMag || phase != heldPh) stableOk = 1'b0;
                if (in_ready) readyLow = 1'b0;
            end
            in_valid = 1'b0;
            checkOutput("stall outputs stable", stableOk, 1, 0, 0);
            checkOutput("stall in_ready low", readyLow, 1, 0, 0);
            checkOutput("stall mag", magnitude, m, MAG_TOL, 0);
            checkOutput("stall phase", phase, p, PH_TOL, 1);
            releaseOutput();
            checkOutput("post handshake out_valid", out_valid, 0, 0, 0);
            checkOutput("post handshake in_ready", in_ready, 1, 0, 0);
            checkOutput("post handshake mag hold", magnitude, heldMag, 0, 0);
            lat = 0;
            for (int c = 0; c < 25; c++) begin
                step();
                if (out_valid) lat++;
            end
            checkOutput("ignored pulse no result", lat, 0, 0, 0);
        end

        $display("[TB] back-to-back");
        begin
            int     bx[4] = '{20000, -15000, 3000, -25000};
            int     by[4] = '{-7000, 12000, 28000, -1000};
            int     resT[4];
            longint resM[4];
            longint resP[4];
            int     nres;
            int     idx;
            int     cyc;
            bit     acc;
            nres      = 0;
            idx       = 0;
            cyc       = 0;
            in_valid  = 1'b1;
            out_ready = 1'b1;
            x_in      = 16'(bx[0]);
            y_in      = 16'(by[0]);
            while (nres < 4 && cyc < 300) begin
                if (out_valid) begin
                    resT[nres] = cyc;
                    resM[nres] = magnitude;
                    resP[nres] = phase;
                    nres++;
                end
                acc = in_ready && in_valid;
                step();
                cyc++;
                if (acc) begin
                    idx++;
                    if (idx < 4) begin
                        x_in = 16'(bx[idx]);
                        y_in = 16'(by[idx]);
                    end else begin
                        in_valid = 1'b0;
                    end
                end
            end
            in_valid  = 1'b0;
            out_ready = 1'b0;
            checkOutput("b2b result count", nres, 4, 0, 0);
            for (int k = 0; k < nres; k++) begin
                refModel(bx[k], by[k], m, rm, p);
                checkOutput("b2b mag", resM[k], m, MAG_TOL, 0);
                checkOutput("b2b phase", resP[k], p, PH_TOL, 1);
                if (k > 0) checkOutput("b2b spacing", resT[k] - resT[k-1], 19, 0, 0);
            end
        end

        $display("[TB] reset mid-operation");
        begin
            int seen;
            step();
            in_valid = 1'b1;
            x_in     = 16'(9000);
            y_in     = 16'(9000);
            checkOutput("pre-reset in_ready", in_ready, 1, 0, 0);
            step();
            in_valid = 1'b0;
            for (int c = 0; c < 7; c++) step();
            rst_n = 1'b0;
            #1;
            checkOutput("mid reset out_valid", out_valid, 0, 0, 0);
            checkOutput("mid reset in_ready", in_ready, 1, 0, 0);
            step();
            step();
            rst_n = 1'b1;
            seen = 0;
            for (int c = 0; c < 25; c++) begin
                step();
                if (out_valid) seen++;
            end
            checkOutput("discarded sample no result", seen, 0, 0, 0);
            runChecked("after reset", -7000, 21000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
